// File: rtl/vid_pkg.sv
// Shared bus encodings, burst length codes and fetch FSM states for the video
// line fetch stage.
package vid_pkg;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_WDATA = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_RDATA = 3'b011;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_WRESP = 3'b101;

    localparam logic [1:0] LEN_1 = 2'b00;
    localparam logic [1:0] LEN_2 = 2'b01;
    localparam logic [1:0] LEN_4 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_BID  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BID  = 2'b01,
        ADDR = 2'b10,
        DATA = 2'b11
    } fetch_state_t;

    // Map a burst beat count onto the lenout encoding; unsupported sizes fall back to 4.
    function automatic logic [1:0] len_code(input int beats);
        case (beats)
            1:       len_code = LEN_1;
            2:       len_code = LEN_2;
            8:       len_code = LEN_8;
            default: len_code = LEN_4;
        endcase
    endfunction

endpackage

// File: rtl/vid_line_addr_gen.sv
// Line and burst address bookkeeping: tracks the start address of the current
// and next line and the address of the next burst to be fetched.
module vid_line_addr_gen #(
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [31:0] base_address,
    input  logic [31:0] lineinc,
    input  logic        burst_done,
    input  logic        pending_line,
    output logic [31:0] fetch_addr
);

    logic [31:0] next_line_addr;
    logic [31:0] line_addr;
    logic [31:0] start_addr;

    // frame_start arrives together with the first line_start, so that line
    // starts directly at the base address.
    assign start_addr = frame_start ? base_address : next_line_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_line_addr <= '0;
            line_addr      <= '0;
            fetch_addr     <= '0;
        end else begin
            if (line_start) begin
                line_addr      <= start_addr;
                next_line_addr <= start_addr + lineinc;
            end else if (frame_start) begin
                next_line_addr <= base_address;
            end

            // A burst that ends after a new line began restarts at that line.
            if (burst_done) begin
                if (line_start)
                    fetch_addr <= start_addr;
                else if (pending_line)
                    fetch_addr <= line_addr;
                else
                    fetch_addr <= fetch_addr + 32'(4 * BURST_LEN);
            end else if (line_start) begin
                fetch_addr <= start_addr;
            end
        end
    end

endmodule

// File: rtl/vid_line_fetch.sv
// Bus-master pixel fetch: reads each active line in fixed-length read bursts and
// pushes the low 24 bits of every useful beat into the downstream RGB FIFO.
module vid_line_fetch
    import vid_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         BURST_LEN  = 4,
    parameter logic [3:0] MEM_TARGET = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [31:0] base_address,
    input  logic [31:0] lineinc,
    input  logic [12:0] hsize,
    input  logic [4:0]  fifo_count,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [3:0]  reqtar,
    output logic [2:0]  cmdout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic        fifo_wr,
    output logic [23:0] fifo_wdata,
    output logic        line_done,
    output logic        busy
);

    fetch_state_t state, state_nx;

    logic [12:0] words_left;
    logic [2:0]  beat_cnt;
    logic        pending_line;
    logic        last_wr;
    logic [31:0] fetch_addr;
    logic        beat;
    logic        keep_beat;
    logic        burst_done;
    logic        room;
    logic        unused_hi;

    assign unused_hi = ^addrdatain[31:24];

    // Handshake: a beat is any DATA-state cycle where the bus selects us with
    // RDATA; other cycles are wait states. The bid is held until ackin.
    assign beat       = (state == DATA) && selin && (cmdin == CMD_RDATA);
    assign keep_beat  = beat && (words_left != 13'd0) && !pending_line && !line_start;
    assign burst_done = beat && (beat_cnt == 3'(BURST_LEN - 1));
    assign room       = (int'(fifo_count) + BURST_LEN) <= FIFO_DEPTH;
    assign busy       = (state != IDLE);

    vid_line_addr_gen #(
        .BURST_LEN(BURST_LEN)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .line_start   (line_start),
        .base_address (base_address),
        .lineinc      (lineinc),
        .burst_done   (burst_done),
        .pending_line (pending_line),
        .fetch_addr   (fetch_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        reqout      = REQ_NONE;
        reqtar      = 4'b0000;
        cmdout      = CMD_IDLE;
        lenout      = 2'b00;
        addrdataout = '0;
        case (state)
            IDLE: begin
                // Hold off while a new line is loading so the bid uses its counters.
                if (enable && (words_left != 13'd0) && room && !line_start)
                    state_nx = BID;
            end
            BID: begin
                reqout = REQ_BID;
                reqtar = MEM_TARGET;
                if (ackin)
                    state_nx = ADDR;
            end
            ADDR: begin
                cmdout      = CMD_READ;
                lenout      = len_code(BURST_LEN);
                addrdataout = fetch_addr;
                state_nx    = DATA;
            end
            DATA: begin
                if (burst_done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_left   <= '0;
            beat_cnt     <= '0;
            pending_line <= 1'b0;
        end else begin
            if (line_start)
                words_left <= hsize;
            else if (keep_beat)
                words_left <= words_left - 13'd1;

            if (state == ADDR)
                beat_cnt <= '0;
            else if (beat)
                beat_cnt <= beat_cnt + 3'd1;

            // Marks an in-flight burst whose remaining beats belong to an old line.
            if (line_start && (state != IDLE))
                pending_line <= 1'b1;
            else if (state == IDLE)
                pending_line <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr    <= 1'b0;
            fifo_wdata <= '0;
            last_wr    <= 1'b0;
            line_done  <= 1'b0;
        end else begin
            fifo_wr   <= keep_beat;
            last_wr   <= keep_beat && (words_left == 13'd1);
            line_done <= last_wr;
            if (keep_beat)
                fifo_wdata <= addrdatain[23:0];
        end
    end

endmodule

// File: tb/tb_vid_line_fetch.sv
// Bench for vid_line_fetch: a cycle table for the first line, then directed
// sequences for line stepping, partial bursts, FIFO room, line abort and reset.
module tb_vid_line_fetch;
    import vid_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_start;
    logic        line_start;
    logic [31:0] base_address;
    logic [31:0] lineinc;
    logic [12:0] hsize;
    logic [4:0]  fifo_count;
    logic        selin;
    logic [2:0]  cmdin;
    logic [31:0] addrdatain;
    logic        ackin;
    logic [1:0]  reqout;
    logic [3:0]  reqtar;
    logic [2:0]  cmdout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic        fifo_wr;
    logic [23:0] fifo_wdata;
    logic        line_done;
    logic        busy;

    vid_line_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .frame_start  (frame_start),
        .line_start   (line_start),
        .base_address (base_address),
        .lineinc      (lineinc),
        .hsize        (hsize),
        .fifo_count   (fifo_count),
        .selin        (selin),
        .cmdin        (cmdin),
        .addrdatain   (addrdatain),
        .ackin        (ackin),
        .reqout       (reqout),
        .reqtar       (reqtar),
        .cmdout       (cmdout),
        .lenout       (lenout),
        .addrdataout  (addrdataout),
        .fifo_wr      (fifo_wr),
        .fifo_wdata   (fifo_wdata),
        .line_done    (line_done),
        .busy         (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ld_cnt   = 0;
    logic sb_on  = 1'b0;
    logic [23:0] pix = 24'h000001;
    logic [23:0] exp_q[$];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check / scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && line_done)
            ld_cnt++;
        if (sb_on && !reset && fifo_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_wr actual=%0h required=no_write", fifo_wdata);
            end else begin
                check("sb_pixel", 32'(fifo_wdata), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_line(input logic fs);
        line_start  = 1'b1;
        frame_start = fs;
        cycle();
        line_start  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic do_beat(input logic keep);
        selin      = 1'b1;
        cmdin      = CMD_RDATA;
        addrdatain = {8'hC3, pix};
        if (keep)
            exp_q.push_back(pix);
        pix = pix + 24'h000101;
        cycle();
        selin      = 1'b0;
        cmdin      = CMD_IDLE;
        addrdatain = '0;
    endtask

    task automatic wait_bid(input string name);
        int n = 0;
        while (reqout != REQ_BID && n < 30) begin
            cycle();
            n++;
        end
        check({name, "_bid"}, 32'(reqout), 32'(REQ_BID));
        check({name, "_tar"}, 32'(reqtar), 32'h1);
    endtask

    task automatic serve_burst(input string name, input logic [31:0] exp_addr,
                               input int nkeep, input int nbeats);
        wait_bid(name);
        ackin = 1'b1;
        cycle();
        ackin = 1'b0;
        check({name, "_cmd"}, 32'(cmdout), 32'(CMD_READ));
        check({name, "_len"}, 32'(lenout), 32'(LEN_4));
        check({name, "_addr"}, addrdataout, exp_addr);
        cycle();
        for (int b = 0; b < nbeats; b++)
            do_beat(b < nkeep);
    endtask

    task automatic drain(input string name);
        repeat (3) cycle();
        check({name, "_q_empty"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic quiet(input string name, input int n);
        int bad = 0;
        repeat (n) begin
            cycle();
            if (reqout != REQ_NONE || busy)
                bad++;
        end
        check(name, 32'(bad), 32'h0);
    endtask

    // ---------------- cycle table for the first line ----------------
    typedef struct {
        logic        ls, fs, ack, sel;
        logic [2:0]  cmd;
        logic [31:0] data;
        logic [1:0]  e_req;
        logic [2:0]  e_cmd;
        logic [1:0]  e_len;
        logic [31:0] e_addr;
        logic        e_wr;
        logic [23:0] e_wdata;
        logic        e_done;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic ls, input logic fs, input logic ack, input logic sel,
                           input logic [2:0] cmd, input logic [31:0] data,
                           input logic [1:0] e_req, input logic [2:0] e_cmd,
                           input logic [1:0] e_len, input logic [31:0] e_addr,
                           input logic e_wr, input logic [23:0] e_wdata,
                           input logic e_done, input logic e_busy);
        vec_t v;
        v.ls = ls; v.fs = fs; v.ack = ack; v.sel = sel; v.cmd = cmd; v.data = data;
        v.e_req = e_req; v.e_cmd = e_cmd; v.e_len = e_len; v.e_addr = e_addr;
        v.e_wr = e_wr; v.e_wdata = e_wdata; v.e_done = e_done; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ld0;
        reset        = 1'b1;
        enable       = 1'b1;
        frame_start  = 1'b0;
        line_start   = 1'b0;
        base_address = 32'h0000_1000;
        lineinc      = 32'h0000_0100;
        hsize        = 13'd8;
        fifo_count   = 5'd0;
        selin        = 1'b0;
        cmdin        = CMD_IDLE;
        addrdatain   = '0;
        ackin        = 1'b0;

        //       ls  fs  ack sel cmd        data           req       cmd       len    addr          wr  wdata        done busy
        add_vec('1, '1, '0, '0, CMD_IDLE,  32'h0,         REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '0, 24'h0,       '0, '0);
        add_vec('0, '0, '0, '0, CMD_IDLE,  32'h0,         REQ_BID,  CMD_IDLE, LEN_1, 32'h0,        '0, 24'h0,       '0, '1);
        add_vec('0, '0, '1, '0, CMD_IDLE,  32'h0,         REQ_NONE, CMD_READ, LEN_4, 32'h1000,     '0, 24'h0,       '0, '1);
        add_vec('0, '0, '0, '0, CMD_IDLE,  32'h0,         REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '0, 24'h0,       '0, '1);
        add_vec('0, '0, '0, '1, CMD_RDATA, 32'hFF11_1111, REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '1, 24'h111111,  '0, '1);
        add_vec('0, '0, '0, '1, CMD_IDLE,  32'h0,         REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '0, 24'h0,       '0, '1);
        add_vec('0, '0, '0, '1, CMD_RDATA, 32'h0022_2222, REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '1, 24'h222222,  '0, '1);
        add_vec('0, '0, '0, '1, CMD_RDATA, 32'h1233_3333, REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '1, 24'h333333,  '0, '1);
        add_vec('0, '0, '0, '0, CMD_RDATA, 32'h0099_9999, REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '0, 24'h0,       '0, '1);
        add_vec('0, '0, '0, '1, CMD_RDATA, 32'h0044_4444, REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '1, 24'h444444,  '0, '0);
        add_vec('0, '0, '0, '0, CMD_IDLE,  32'h0,         REQ_BID,  CMD_IDLE, LEN_1, 32'h0,        '0, 24'h0,       '0, '1);
        add_vec('0, '0, '1, '0, CMD_IDLE,  32'h0,         REQ_NONE, CMD_READ, LEN_4, 32'h1010,     '0, 24'h0,       '0, '1);
        add_vec('0, '0, '0, '0, CMD_IDLE,  32'h0,         REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '0, 24'h0,       '0, '1);
        add_vec('0, '0, '0, '1, CMD_RDATA, 32'h0055_5555, REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '1, 24'h555555,  '0, '1);
        add_vec('0, '0, '0, '1, CMD_RDATA, 32'h0066_6666, REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '1, 24'h666666,  '0, '1);
        add_vec('0, '0, '0, '1, CMD_RDATA, 32'h0077_7777, REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '1, 24'h777777,  '0, '1);
        add_vec('0, '0, '0, '1, CMD_RDATA, 32'hAB88_8888, REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '1, 24'h888888,  '0, '0);
        add_vec('0, '0, '0, '0, CMD_IDLE,  32'h0,         REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '0, 24'h0,       '1, '0);
        add_vec('0, '0, '0, '0, CMD_IDLE,  32'h0,         REQ_NONE, CMD_IDLE, LEN_1, 32'h0,        '0, 24'h0,       '0, '0);

        // Reset state
        #3;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_reqout", 32'(reqout), 32'h0);
        check("rst_fifo_wr", 32'(fifo_wr), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();

        foreach (vecs[i]) begin
            line_start  = vecs[i].ls;
            frame_start = vecs[i].fs;
            ackin       = vecs[i].ack;
            selin       = vecs[i].sel;
            cmdin       = vecs[i].cmd;
            addrdatain  = vecs[i].data;
            cycle();
            check($sformatf("v%0d_req", i), 32'(reqout), 32'(vecs[i].e_req));
            check($sformatf("v%0d_cmd", i), 32'(cmdout), 32'(vecs[i].e_cmd));
            check($sformatf("v%0d_len", i), 32'(lenout), 32'(vecs[i].e_len));
            check($sformatf("v%0d_addr", i), addrdataout, vecs[i].e_addr);
            check($sformatf("v%0d_wr", i), 32'(fifo_wr), 32'(vecs[i].e_wr));
            if (vecs[i].e_wr)
                check($sformatf("v%0d_wdata", i), 32'(fifo_wdata), 32'(vecs[i].e_wdata));
            check($sformatf("v%0d_done", i), 32'(line_done), 32'(vecs[i].e_done));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end
        line_start = 1'b0;
        frame_start = 1'b0;
        ackin = 1'b0;
        selin = 1'b0;
        cmdin = CMD_IDLE;
        addrdatain = '0;
        sb_on = 1'b1;

        // Line stepping and frame restart
        hsize = 13'd4;
        ld0 = ld_cnt;
        pulse_line(1'b0);
        serve_burst("line2", 32'h1100, 4, 4);
        drain("line2");
        pulse_line(1'b0);
        serve_burst("line3", 32'h1200, 4, 4);
        drain("line3");
        pulse_line(1'b1);
        serve_burst("frame", 32'h1000, 4, 4);
        drain("frame");
        check("step_line_done", 32'(ld_cnt - ld0), 32'h3);

        // Partial last burst
        hsize = 13'd6;
        ld0 = ld_cnt;
        pulse_line(1'b0);
        serve_burst("h6_b1", 32'h1100, 4, 4);
        serve_burst("h6_b2", 32'h1110, 2, 4);
        drain("h6");
        check("h6_line_done", 32'(ld_cnt - ld0), 32'h1);
        quiet("h6_no_third_bid", 6);

        // FIFO room threshold
        hsize = 13'd4;
        fifo_count = 5'd13;
        pulse_line(1'b0);
        quiet("full_no_bid", 5);
        fifo_count = 5'd12;
        cycle();
        check("room_bid_next", 32'(reqout), 32'(REQ_BID));
        serve_burst("room", 32'h1200, 4, 4);
        fifo_count = 5'd0;
        drain("room");

        // New line mid-burst
        hsize = 13'd8;
        ld0 = ld_cnt;
        pulse_line(1'b0);
        serve_burst("ab_old", 32'h1300, 2, 2);
        hsize = 13'd4;
        pulse_line(1'b0);
        do_beat(1'b0);
        do_beat(1'b0);
        serve_burst("ab_new", 32'h1400, 4, 4);
        drain("ab");
        check("ab_line_done", 32'(ld_cnt - ld0), 32'h1);

        // Async reset during DATA
        pulse_line(1'b0);
        wait_bid("rst_mid");
        ackin = 1'b1;
        cycle();
        ackin = 1'b0;
        cycle();
        do_beat(1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_fifo_wr", 32'(fifo_wr), 32'h0);
        check("midrst_wdata", 32'(fifo_wdata), 32'h0);
        check("midrst_reqout", 32'(reqout), 32'h0);
        check("midrst_cmdout", 32'(cmdout), 32'h0);
        #1;
        reset = 1'b0;
        quiet("post_rst_no_bid", 8);
        check("final_q_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
